// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch requester.
//               - fetch_tag_t   : tag-queue entry {addr, kill}
//               - fetch_state_e : request state {IDLE, REQ}
//               - ALIGN_MASK    : clears bits [1:0] to word-align an address
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Data/address width carried by the tag queue; the top-level XLEN must match.
  localparam int unsigned FETCH_XLEN = 32;

  localparam logic [FETCH_XLEN-1:0] ALIGN_MASK = {{(FETCH_XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] addr;
    logic                  kill;
  } fetch_tag_t;

endpackage
`default_nettype wire

// File: rtl/fetch_tag_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_tag_queue
// Description : In-order tag FIFO for outstanding fetch transactions. Each
//               entry records the address to report and whether the response
//               must be discarded. kill_all_i marks every valid entry killed.
// Ports       : clk_i, rst_ni      - clock, async active-low reset
//               push_i/push_entry_i - enqueue an entry
//               pop_i               - dequeue the head
//               kill_all_i          - set kill on all valid entries
//               head_o / empty_o    - head entry and empty flag
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_tag_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  fetch_tag_t push_entry_i,
  input  logic       pop_i,
  input  logic       kill_all_i,
  output fetch_tag_t head_o,
  output logic       empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_tag_t       entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;

  // Wrap explicitly so DEPTH need not fill the pointer range.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_all_i && valid_q[i]) begin
          entry_q[i].kill <= 1'b1;
        end
      end
      if (pop_i) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= next_ptr(rd_ptr_q);
      end
      // A push written last wins over a broadcast kill of the same slot; the
      // pushed entry already carries the kill when a flush coincides.
      if (push_i) begin
        entry_q[wr_ptr_q] <= push_entry_i;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= next_ptr(wr_ptr_q);
      end
    end
  end

  assign head_o  = entry_q[rd_ptr_q];
  assign empty_o = !valid_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fetch_req_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_req_unit
// Description : Instruction-fetch requester feeding the prefetch FIFO. Issues
//               word-aligned reads over req/gnt/rvalid, tracks outstanding
//               transactions and drops responses of flushed streams.
// Ports       : clk_i, rst_ni                 - clock, async active-low reset
//               fetch_ready_i                 - FIFO has room for a burst
//               branch_i / branch_addr_i      - redirect pulse and target
//               imem_req_o/imem_addr_o/imem_gnt_i - request handshake
//               imem_rvalid_i/imem_rdata_i    - read response
//               out_addr_o/out_instr_o/out_valid_o - delivered word to FIFO
//               busy_o                        - requests pending/outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_req_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN            = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h1000_0000,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fetch_ready_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_addr_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] out_addr_o,
  output logic [XLEN-1:0] out_instr_o,
  output logic            out_valid_o,
  output logic            busy_o
);

  localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  fetch_addr_q, fetch_addr_d;
  logic             first_q, first_d;
  logic [XLEN-1:0]  req_tag_q, req_tag_d;     // tag of the request held in REQ
  logic             req_kill_q, req_kill_d;   // held request flushed before grant
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_addr_q, out_addr_d;
  logic [XLEN-1:0]  out_instr_q, out_instr_d;

  logic             issue;
  logic             req;
  logic             start;
  logic             grant;
  logic [XLEN-1:0]  cur_tag;
  logic             cur_kill;
  fetch_tag_t       push_entry;
  fetch_tag_t       head;
  logic             q_empty;

  assign issue = fetch_ready_i && !branch_i && (cnt_q < CNT_MAX);

  // --------------------------------------------------------------------------
  // Request state machine and fetch address tracking
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    first_d      = first_q;
    req_tag_d    = req_tag_q;
    req_kill_d   = req_kill_q;
    req          = 1'b0;
    start        = 1'b0;
    cur_tag      = req_tag_q;
    cur_kill     = req_kill_q | branch_i;

    case (state_q)
      IDLE: begin
        // The first word after reset/redirect keeps bit1 so the FIFO sees the
        // exact target address; later words report the aligned address.
        cur_tag  = first_q ? fetch_addr_q : (fetch_addr_q & ALIGN_MASK);
        cur_kill = 1'b0;
        if (issue) begin
          req   = 1'b1;
          start = 1'b1;
          if (!imem_gnt_i) begin
            state_d    = REQ;
            req_tag_d  = cur_tag;
            req_kill_d = 1'b0;
          end
        end
      end
      REQ: begin
        req = 1'b1;
        if (branch_i) begin
          req_kill_d = 1'b1;
        end
        if (imem_gnt_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    grant = req && imem_gnt_i;

    // A killed grant must not advance the address: it already holds the target.
    if (grant && !cur_kill) begin
      fetch_addr_d = (cur_tag & ALIGN_MASK) + XLEN'(4);
      first_d      = 1'b0;
    end
    if (branch_i) begin
      fetch_addr_d = branch_addr_i;
      first_d      = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outstanding counter and response delivery
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    case ({start, imem_rvalid_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    out_valid_d = imem_rvalid_i && !head.kill && !branch_i;
    out_addr_d  = out_addr_q;
    out_instr_d = out_instr_q;
    if (out_valid_d) begin
      out_addr_d  = head.addr;
      out_instr_d = imem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_PC;
      first_q      <= 1'b1;
      req_tag_q    <= '0;
      req_kill_q   <= 1'b0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_instr_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      first_q      <= first_d;
      req_tag_q    <= req_tag_d;
      req_kill_q   <= req_kill_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_instr_q  <= out_instr_d;
    end
  end

  assign push_entry = '{addr: cur_tag, kill: cur_kill};

  fetch_tag_queue #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_queue (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (grant),
    .push_entry_i (push_entry),
    .pop_i        (imem_rvalid_i),
    .kill_all_i   (branch_i),
    .head_o       (head),
    .empty_o      (q_empty)
  );

  assign imem_req_o  = req;
  assign imem_addr_o = cur_tag & ALIGN_MASK;
  assign out_valid_o = out_valid_q;
  assign out_addr_o  = out_addr_q;
  assign out_instr_o = out_instr_q;
  assign busy_o      = (cnt_q != '0);

`ifndef SYNTHESIS
  // A response without a matching queued request is a protocol violation.
  a_rvalid_has_tag: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rvalid_i |-> !q_empty);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_req_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_req_unit
// Description : Randomized self-checking bench for fetch_req_unit. The bench
//               plays instruction memory and keeps a transaction-level model
//               (fetch PC, held request, queue of outstanding tags) that
//               predicts requests, addresses, busy and delivered words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_req_unit;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h1000_0000;
  localparam logic [31:0] AMASK    = 32'hFFFF_FFFC;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fetch_ready_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] out_addr_o;
  logic [31:0] out_instr_o;
  logic        out_valid_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  fetch_req_unit #(
    .XLEN            (XLEN),
    .RESET_PC        (RESET_PC),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fetch_ready_i (fetch_ready_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .out_addr_o    (out_addr_o),
    .out_instr_o   (out_instr_o),
    .out_valid_o   (out_valid_o),
    .busy_o        (busy_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    bit          kill;
  } tag_t;

  tag_t        mq[$];            // outstanding granted transactions, in order
  logic [31:0] m_pc      = RESET_PC;
  bit          m_first   = 1'b1;
  bit          m_pend    = 1'b0; // a request is on the bus, not yet granted
  logic [31:0] m_pend_tag;
  bit          m_pend_kill;
  bit          m_dlv     = 1'b0;
  logic [31:0] m_out_addr  = '0;
  logic [31:0] m_out_instr = '0;
  logic [31:0] grant_log[$];

  function automatic logic [31:0] pick_target();
    case ($urandom_range(4))
      0:       return 32'h2000_0012;
      1:       return 32'hFFFF_FFFC;
      2:       return 32'hFFFF_FFF8;
      3:       return 32'h3000_0000;
      default: return $urandom & 32'hFFFF_FFFE;
    endcase
  endfunction

  function automatic int find_grant(input logic [31:0] a);
    foreach (grant_log[i]) if (grant_log[i] == a) return i;
    return -1;
  endfunction

  // One clock: drive inputs, check outputs, then advance the model.
  task automatic run_cycle(input int p_ready, input int p_gnt, input int p_rv,
                           input int p_br, input bit fixed, input logic [31:0] tgt);
    tag_t e;
    bit   req_exp;
    int   cnt;
    @(negedge clk_i);
    fetch_ready_i = ($urandom_range(99) < p_ready);
    branch_i      = ($urandom_range(99) < p_br);
    branch_addr_i = fixed ? tgt : pick_target();
    imem_gnt_i    = ($urandom_range(99) < p_gnt);
    imem_rvalid_i = (mq.size() != 0) && ($urandom_range(99) < p_rv);
    imem_rdata_i  = $urandom;
    #1;
    check_val("out_valid", out_valid_o, m_dlv);
    check_val("out_addr", out_addr_o, m_out_addr);
    check_val("out_instr", out_instr_o, m_out_instr);
    cnt = mq.size() + int'(m_pend);
    check_val("busy", busy_o, cnt != 0);
    if (m_pend) begin
      req_exp = 1'b1;
      check_val("req_held", imem_req_o, 1'b1);
      check_val("addr_held", imem_addr_o, m_pend_tag & AMASK);
    end else begin
      req_exp = fetch_ready_i && !branch_i && (cnt < MAXO);
      check_val("req_issue", imem_req_o, req_exp);
      if (req_exp) check_val("req_addr", imem_addr_o, m_pc & AMASK);
    end

    if (!m_pend && req_exp) begin
      m_pend      = 1'b1;
      m_pend_tag  = m_first ? m_pc : (m_pc & AMASK);
      m_pend_kill = 1'b0;
    end
    m_dlv = 1'b0;
    if (imem_rvalid_i) begin
      e = mq.pop_front();
      if (!e.kill && !branch_i) begin
        m_dlv       = 1'b1;
        m_out_addr  = e.addr;
        m_out_instr = imem_rdata_i;
      end
    end
    if (m_pend && imem_gnt_i) begin
      grant_log.push_back(m_pend_tag & AMASK);
      e.addr = m_pend_tag;
      e.kill = m_pend_kill || branch_i;
      mq.push_back(e);
      if (!e.kill) begin
        m_pc    = (m_pend_tag & AMASK) + 32'd4;
        m_first = 1'b0;
      end
      m_pend = 1'b0;
    end else if (m_pend && branch_i) begin
      m_pend_kill = 1'b1;
    end
    if (branch_i) begin
      foreach (mq[i]) mq[i].kill = 1'b1;
      m_pc    = branch_addr_i;
      m_first = 1'b1;
    end
  endtask

  initial begin
    int idx;
    repeat (2) @(negedge clk_i);
    check_val("rst_req", imem_req_o, 1'b0);
    check_val("rst_out_valid", out_valid_o, 1'b0);
    check_val("rst_out_addr", out_addr_o, 32'h0);
    check_val("rst_out_instr", out_instr_o, 32'h0);
    check_val("rst_busy", busy_o, 1'b0);
    rst_ni = 1'b1;

    // Streaming fetch from reset with immediate grants.
    for (int i = 0; i < 8; i++) run_cycle(100, 100, 100, 0, 1'b0, '0);
    check_val("stream_n", grant_log.size() >= 3, 1'b1);
    if (grant_log.size() >= 3) begin
      check_val("stream_a0", grant_log[0], 32'h1000_0000);
      check_val("stream_a1", grant_log[1], 32'h1000_0004);
      check_val("stream_a2", grant_log[2], 32'h1000_0008);
    end

    // Grant withheld: request and address must hold.
    for (int i = 0; i < 6; i++) run_cycle(100, 0, 100, 0, 1'b0, '0);

    // Build outstanding requests, then redirect to a bit1-set target.
    for (int i = 0; i < 3; i++) run_cycle(100, 100, 0, 0, 1'b0, '0);
    grant_log.delete();
    run_cycle(100, 100, 0, 100, 1'b1, 32'h2000_0012);
    for (int i = 0; i < 10; i++) run_cycle(100, 100, 100, 0, 1'b0, '0);
    idx = find_grant(32'h2000_0010);
    check_val("br_target_found", idx >= 0, 1'b1);
    if (idx >= 0 && idx + 1 < grant_log.size())
      check_val("br_target_next", grant_log[idx+1], 32'h2000_0014);

    // Address wrap at the top of the address space.
    grant_log.delete();
    run_cycle(100, 100, 100, 100, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 10; i++) run_cycle(100, 100, 100, 0, 1'b0, '0);
    idx = find_grant(32'hFFFF_FFFC);
    check_val("wrap_found", idx >= 0, 1'b1);
    if (idx >= 0 && idx + 1 < grant_log.size())
      check_val("wrap_next", grant_log[idx+1], 32'h0000_0000);

    // Randomized traffic with varying pressure.
    for (int i = 0; i < 500; i++) run_cycle(80, 50, 50, 10, 1'b0, '0);
    for (int i = 0; i < 500; i++) run_cycle(100, 20, 30, 25, 1'b0, '0);
    for (int i = 0; i < 500; i++) run_cycle(60, 90, 90, 5, 1'b0, '0);
    for (int i = 0; i < 500; i++) run_cycle(100, 70, 20, 40, 1'b0, '0);

    // Drain and confirm idle.
    for (int i = 0; i < 10; i++) run_cycle(0, 100, 100, 0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
